ula_result_display: RTL and testbench
=====================================

Name: ula_result_display

Overview:
- Downstream stage of the ALU. Captures one ALU result word plus its zero/overflow flags through a valid/ready handshake.
- Converts the magnitude to BCD with a sequential shift-add-3 (double-dabble) FSM.
- Drives four active-low 7-segment digits (HEX3..HEX0) and two status LEDs on the board.
- Replaces the raw binary LEDR readout with a decimal, optionally signed, display.

Parameters:
- DATA_W, 6, width of the result word; legal range 4..9, so the value always fits 3 BCD digits.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  result word and flags are valid this cycle.
- in_ready  out  1  block can accept a word; high only in IDLE.
- result  in  DATA_W  ALU result bits (carry/overflow bit excluded).
- signed_mode  in  1  1 = interpret result as two's complement; 0 = unsigned.
- ovf_in  in  1  ALU overflow flag belonging to result.
- zero_in  in  1  ALU zero flag belonging to result.
- HEX0  out  7  ones digit, segments {g,f,e,d,c,b,a}, active-low.
- HEX1  out  7  tens digit.
- HEX2  out  7  hundreds digit.
- HEX3  out  7  sign/error position.
- zero_led  out  1  registered copy of the captured zero_in.
- ovf_led  out  1  registered copy of the captured ovf_in.
- done  out  1  one-cycle pulse when display registers update.

Behaviour:
- Reset (reset_n=0, async):
  - state = IDLE.
  - HEX0..HEX3 = 7'b1111111 (blank).
  - zero_led = 0, ovf_led = 0, done = 0.
  - BCD/shift registers cleared.
  - in_ready = 1 while reset is held.
- FSM states: IDLE, CONV, UPDATE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1, capture result, signed_mode, ovf_in, zero_in.
  - Magnitude = -result (DATA_W-bit two's complement) when signed_mode=1 and result[DATA_W-1]=1; otherwise result. Most-negative input gives magnitude 2^(DATA_W-1), which fits unsigned.
  - Record neg = (signed_mode & MSB). Load a bit counter with DATA_W. Go to CONV.
- CONV:
  - in_ready = 0. in_valid is ignored; words offered here are not queued.
  - Each cycle: every BCD nibble >= 5 gets +3, then shift {bcd, mag} left by 1, then decrement the counter.
  - After exactly DATA_W cycles, go to UPDATE.
- UPDATE (one cycle): at its closing edge, load HEX/LED registers, assert done for the following cycle, return to IDLE.
- Latency:
  - Accepting edge = E0. Outputs change at edge E0+DATA_W+1.
  - done is high from that edge for exactly one cycle; in_ready is high again from the same edge.
  - Throughput: one word per DATA_W+2 cycles.
- Display rules:
  - HEX0 always shows the ones digit.
  - HEX1 is blank if hundreds==0 and tens==0.
  - HEX2 is blank if hundreds==0.
  - HEX3 priority: ovf=1 -> 'E' (7'b0000110); else neg=1 -> '-' (7'b0111111); else blank.
- Digit codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Previous display values hold until the next UPDATE; there is no blanking during CONV.
- A reset mid-CONV aborts the conversion; outputs go to reset values.
- Continuous streaming: in_valid tied high is legal; the block re-samples at every IDLE.

Decomposition:
- Package ula_display_pkg:
  - state enum {IDLE, CONV, UPDATE}
  - SEG_BLANK, SEG_MINUS, SEG_E constants
  - BCD-to-segment lookup function
- Sub-module bcd_to_7seg: combinational 4-bit BCD -> 7-bit active-low segment decoder, instantiated three times.
- The top module holds the FSM, the double-dabble datapath and the output registers.

Test Plan:
- DATA_W=6, unsigned result=63, flags 0:
  - HEX1=6 (0000010), HEX0=3 (0110000), HEX2 and HEX3 blank.
  - done pulses once at edge E0+7; in_ready is low for edges E0+1..E0+6.
- signed_mode=1, result=6'b100000:
  - HEX3='-', HEX1=3, HEX0=2, HEX2 blank.
  - Then result=6'b111111 -> HEX3='-', HEX0=1, HEX1 blank.
- result=0, zero_in=1:
  - HEX0=0 (1000000), HEX1..HEX3 blank, zero_led=1.
  - Next word 5 with zero_in=0 -> zero_led=0, HEX0=5.
- ovf_in=1, signed_mode=1, result=6'b111110:
  - HEX3='E' (overrides '-'), HEX0=2, ovf_led=1.
- Back-to-back and abort:
  - Assert in_valid with result=9 at E0+3 during CONV -> ignored; display still shows the first word.
  - Drop reset_n at E0+3 of a conversion -> all HEX blank immediately, done never pulses, in_ready=1 after release.
- DATA_W=9, unsigned result=511:
  - HEX2=5, HEX1=1, HEX0=1 at edge E0+10.
  - Then result=100 -> HEX2=1, HEX1=0 (not blanked), HEX0=0.

Source files
------------

// File: rtl/ula_display_pkg.sv
// Shared types and segment constants for the ALU result display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package ula_display_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      UPDATE = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;

   // Non-decimal nibbles cannot occur after double-dabble; they decode to blank.
   function automatic logic [6:0] bcd_seg(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder.
module bcd_to_7seg
   import ula_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   assign seg = bcd_seg(bcd);

endmodule

// File: rtl/ula_result_display.sv
// Captures an ALU result with flags, converts its magnitude to BCD by
// double-dabble and drives a signed decimal 7-segment display plus status LEDs.
module ula_result_display
   import ula_display_pkg::*;
#(
   parameter int DATA_W = 6
)
(
   input  logic              CLOCK_50,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] result,
   input  logic              signed_mode,
   input  logic              ovf_in,
   input  logic              zero_in,
   output logic [6:0]        HEX0,
   output logic [6:0]        HEX1,
   output logic [6:0]        HEX2,
   output logic [6:0]        HEX3,
   output logic              zero_led,
   output logic              ovf_led,
   output logic              done
);

   localparam int BCD_W = 12;

   state_t              state_reg, state_next;
   logic [3:0]          cnt_reg;
   logic [BCD_W-1:0]    bcd_reg;
   logic [DATA_W-1:0]   mag_reg;
   logic                neg_reg, ovf_reg, zero_reg;

   logic                accept, conv_step, update;
   logic [DATA_W-1:0]   neg_result, magnitude;
   logic                is_neg;
   logic [BCD_W-1:0]    bcd_adj;
   logic [BCD_W+DATA_W-1:0] shift_next;
   logic [6:0]          seg_ones, seg_tens, seg_hund;

   // State register
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (in_valid) state_next = CONV;
         CONV:    if (cnt_reg == 4'd1) state_next = UPDATE;
         UPDATE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready  = (state_reg == IDLE);
      accept    = (state_reg == IDLE) && in_valid;
      conv_step = (state_reg == CONV);
      update    = (state_reg == UPDATE);
   end

   // The most-negative value negates to 2^(DATA_W-1), still representable unsigned.
   assign is_neg     = signed_mode & result[DATA_W-1];
   assign neg_result = ~result + {{(DATA_W-1){1'b0}}, 1'b1};
   assign magnitude  = is_neg ? neg_result : result;

   genvar gi;
   generate
      for (gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 :
                                     bcd_reg[gi*4 +: 4];
      end
   endgenerate

   assign shift_next = {bcd_adj, mag_reg} << 1;

   // Conversion datapath
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg  <= '0;
         bcd_reg  <= '0;
         mag_reg  <= '0;
         neg_reg  <= 1'b0;
         ovf_reg  <= 1'b0;
         zero_reg <= 1'b0;
      end else if (accept) begin
         cnt_reg  <= 4'(DATA_W);
         bcd_reg  <= '0;
         mag_reg  <= magnitude;
         neg_reg  <= is_neg;
         ovf_reg  <= ovf_in;
         zero_reg <= zero_in;
      end else if (conv_step) begin
         {bcd_reg, mag_reg} <= shift_next;
         cnt_reg            <= cnt_reg - 4'd1;
      end
   end

   bcd_to_7seg u_seg_ones (.bcd(bcd_reg[3:0]),  .seg(seg_ones));
   bcd_to_7seg u_seg_tens (.bcd(bcd_reg[7:4]),  .seg(seg_tens));
   bcd_to_7seg u_seg_hund (.bcd(bcd_reg[11:8]), .seg(seg_hund));

   // Display registers hold their value until the next UPDATE.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         HEX0     <= SEG_BLANK;
         HEX1     <= SEG_BLANK;
         HEX2     <= SEG_BLANK;
         HEX3     <= SEG_BLANK;
         zero_led <= 1'b0;
         ovf_led  <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= update;
         if (update) begin
            HEX0     <= seg_ones;
            HEX1     <= (bcd_reg[11:4] == 8'd0) ? SEG_BLANK : seg_tens;
            HEX2     <= (bcd_reg[11:8] == 4'd0) ? SEG_BLANK : seg_hund;
            HEX3     <= ovf_reg ? SEG_E : (neg_reg ? SEG_MINUS : SEG_BLANK);
            zero_led <= zero_reg;
            ovf_led  <= ovf_reg;
         end
      end
   end

endmodule

// File: tb/tb_ula_result_display.sv
// Self-checking bench for ula_result_display at DATA_W=6 and DATA_W=9,
// with expected digits computed arithmetically from the decimal value.
module tb_ula_result_display;

   logic       clk = 1'b0;
   logic       reset_n;
   always #10 clk = ~clk;

   logic       in_valid [2];
   logic       signed_mode [2];
   logic       ovf_in [2];
   logic       zero_in [2];
   logic       in_ready [2];
   logic       done [2];
   logic       zero_led [2];
   logic       ovf_led [2];
   logic [6:0] hex0 [2];
   logic [6:0] hex1 [2];
   logic [6:0] hex2 [2];
   logic [6:0] hex3 [2];
   logic [5:0] res6;
   logic [8:0] res9;

   int checks = 0;
   int errors = 0;

   logic [6:0] seg_tab [10];
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] MINUS = 7'b0111111;
   localparam logic [6:0] ECHR  = 7'b0000110;

   ula_result_display #(.DATA_W(6)) dut6 (
      .CLOCK_50(clk), .reset_n(reset_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .result(res6),
      .signed_mode(signed_mode[0]), .ovf_in(ovf_in[0]), .zero_in(zero_in[0]),
      .HEX0(hex0[0]), .HEX1(hex1[0]), .HEX2(hex2[0]), .HEX3(hex3[0]),
      .zero_led(zero_led[0]), .ovf_led(ovf_led[0]), .done(done[0])
   );

   ula_result_display #(.DATA_W(9)) dut9 (
      .CLOCK_50(clk), .reset_n(reset_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .result(res9),
      .signed_mode(signed_mode[1]), .ovf_in(ovf_in[1]), .zero_in(zero_in[1]),
      .HEX0(hex0[1]), .HEX1(hex1[1]), .HEX2(hex2[1]), .HEX3(hex3[1]),
      .zero_led(zero_led[1]), .ovf_led(ovf_led[1]), .done(done[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Decimal reference: value -> sign, magnitude -> digits -> segments.
   function automatic void model(input int w, input int r, input bit sm, input bit ov,
                                 output logic [6:0] e0, output logic [6:0] e1,
                                 output logic [6:0] e2, output logic [6:0] e3);
      int mag;
      bit neg;
      int h, t, o;
      neg = sm && (r >= (1 << (w - 1)));
      mag = neg ? (1 << w) - r : r;
      h = mag / 100;
      t = (mag / 10) % 10;
      o = mag % 10;
      e0 = seg_tab[o];
      e1 = (h == 0 && t == 0) ? BLANK : seg_tab[t];
      e2 = (h == 0) ? BLANK : seg_tab[h];
      e3 = ov ? ECHR : (neg ? MINUS : BLANK);
   endfunction

   task automatic drive(input int d, input bit v, input int r, input bit sm, input bit ov, input bit zr);
      in_valid[d]    = v;
      signed_mode[d] = sm;
      ovf_in[d]      = ov;
      zero_in[d]     = zr;
      if (d == 0) res6 = r[5:0];
      else        res9 = r[8:0];
   endtask

   task automatic check_blank(input int d, input string tag);
      chk({tag, "_hex0"}, {25'd0, hex0[d]}, {25'd0, BLANK});
      chk({tag, "_hex1"}, {25'd0, hex1[d]}, {25'd0, BLANK});
      chk({tag, "_hex2"}, {25'd0, hex2[d]}, {25'd0, BLANK});
      chk({tag, "_hex3"}, {25'd0, hex3[d]}, {25'd0, BLANK});
      chk({tag, "_zled"}, {31'd0, zero_led[d]}, 32'd0);
      chk({tag, "_oled"}, {31'd0, ovf_led[d]}, 32'd0);
      chk({tag, "_done"}, {31'd0, done[d]}, 32'd0);
      chk({tag, "_ready"}, {31'd0, in_ready[d]}, 32'd1);
   endtask

   // Called #1 after an edge with the DUT idle. inject_at/abort_at name the
   // edge offset from the accepting edge (0 = not used).
   task automatic xfer(input int d, input int r, input bit sm, input bit ov, input bit zr,
                       input int inject_at, input int abort_at);
      int w;
      logic [6:0] e0, e1, e2, e3;
      w = (d == 1) ? 9 : 6;
      model(w, r, sm, ov, e0, e1, e2, e3);
      chk("ready_idle", {31'd0, in_ready[d]}, 32'd1);
      drive(d, 1'b1, r, sm, ov, zr);
      @(posedge clk); #1;
      drive(d, 1'b0, int'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      for (int k = 1; k <= w; k++) begin
         if (k == inject_at) drive(d, 1'b1, 9, 1'b0, 1'b0, 1'b0);
         if (k == abort_at) begin
            reset_n = 1'b0;
            #1;
            check_blank(d, "abort");
            repeat (3) begin
               @(posedge clk); #1;
               chk("abort_done_held", {31'd0, done[d]}, 32'd0);
            end
            reset_n = 1'b1;
            for (int j = 0; j < w + 2; j++) begin
               @(posedge clk); #1;
               chk("abort_done_after", {31'd0, done[d]}, 32'd0);
               chk("abort_ready_after", {31'd0, in_ready[d]}, 32'd1);
            end
            return;
         end
         @(posedge clk); #1;
         in_valid[d] = 1'b0;
         chk("conv_ready_low", {31'd0, in_ready[d]}, 32'd0);
         chk("conv_done_low", {31'd0, done[d]}, 32'd0);
      end
      @(posedge clk); #1;
      chk("done_pulse", {31'd0, done[d]}, 32'd1);
      chk("ready_back", {31'd0, in_ready[d]}, 32'd1);
      chk("hex0", {25'd0, hex0[d]}, {25'd0, e0});
      chk("hex1", {25'd0, hex1[d]}, {25'd0, e1});
      chk("hex2", {25'd0, hex2[d]}, {25'd0, e2});
      chk("hex3", {25'd0, hex3[d]}, {25'd0, e3});
      chk("zero_led", {31'd0, zero_led[d]}, {31'd0, zr});
      chk("ovf_led", {31'd0, ovf_led[d]}, {31'd0, ov});
      @(posedge clk); #1;
      chk("done_one_cycle", {31'd0, done[d]}, 32'd0);
      chk("hex0_hold", {25'd0, hex0[d]}, {25'd0, e0});
      $display("xfer W=%0d result=%0d signed=%0d ovf=%0d zero=%0d hex=%b/%b/%b/%b",
               w, r, sm, ov, zr, hex3[d], hex2[d], hex1[d], hex0[d]);
   endtask

   initial begin
      seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
      seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
      seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
      seg_tab[9] = 7'b0010000;
      reset_n = 1'b0;
      drive(0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_blank(0, "reset6");
      check_blank(1, "reset9");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases, DATA_W=6
      xfer(0, 63, 1'b0, 1'b0, 1'b0, 0, 0);
      xfer(0, 32, 1'b1, 1'b0, 1'b0, 0, 0);
      xfer(0, 63, 1'b1, 1'b0, 1'b0, 0, 0);
      xfer(0, 0,  1'b0, 1'b0, 1'b1, 0, 0);
      xfer(0, 5,  1'b0, 1'b0, 1'b0, 0, 0);
      xfer(0, 62, 1'b1, 1'b1, 1'b0, 0, 0);
      xfer(0, 47, 1'b0, 1'b0, 1'b1, 3, 0);
      xfer(0, 40, 1'b0, 1'b0, 0, 0, 3);
      xfer(0, 31, 1'b1, 1'b0, 1'b0, 0, 0);

      // Directed cases, DATA_W=9
      xfer(1, 511, 1'b0, 1'b0, 1'b0, 0, 0);
      xfer(1, 100, 1'b0, 1'b0, 1'b0, 0, 0);
      xfer(1, 256, 1'b1, 1'b0, 1'b0, 0, 0);
      xfer(1, 255, 1'b1, 1'b1, 1'b1, 0, 0);

      // Randomized words on both widths
      for (int i = 0; i < 40; i++) begin
         int d;
         d = int'($urandom_range(0, 1));
         xfer(d, int'($urandom_range(0, (d == 1) ? 511 : 63)),
              1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
